// File: rtl/riscv_uart_prog_if.sv
// riscv_uart_prog_if
//   Memory-programmer bus between the UART programming engine (master) and
//   the instruction/data RAM wrappers (slave).
//   upg_wen_o   : one-cycle word write strobe
//   upg_adr_o   : [14] target (0 = instruction RAM, 1 = data RAM), [13:0] word address
//   upg_dat_o   : 32-bit write data
//   upg_done_o  : programming finished, memories handed back to the CPU
interface riscv_uart_prog_if;
    logic        upg_wen_o;
    logic [14:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;

    modport master (
        output upg_wen_o,
        output upg_adr_o,
        output upg_dat_o,
        output upg_done_o
    );

    modport slave (
        input upg_wen_o,
        input upg_adr_o,
        input upg_dat_o,
        input upg_done_o
    );
endinterface

// File: rtl/riscv_uart_prog.sv
// riscv_uart_prog
//   UART programming engine. Deserializes an 8N1 stream on rx, parses the
//   framed load protocol (SYNC 0x5A, TGT, ADDR_L, ADDR_H, CNT_L, CNT_H, then
//   CNT little-endian words) and issues one-cycle word writes to the RAMs.
//   Ports:
//     clk   : programmer clock
//     rst   : synchronous active-high reset
//     rx    : UART serial input, idle high, asynchronous to clk
//     upg   : programmer bus (master modport), see riscv_uart_prog_if
//     err_o : sticky protocol/framing error flag, cleared only by rst
module riscv_uart_prog #(
    parameter int CLKS_PER_BIT = 78
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    riscv_uart_prog_if.master         upg,
    output logic                      err_o
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      r_rx_state, w_rx_next;
    logic           r_rx_meta, r_rx_sync;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic           w_half_hit, w_bit_hit;
    logic           w_byte_valid, w_frame_err;

    assign w_half_hit = (r_cnt == CW'(HALF - 1));
    assign w_bit_hit  = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_meta  <= rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_state <= w_rx_next;
        end
    end

    always_comb begin
        w_rx_next    = r_rx_state;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (!r_rx_sync) w_rx_next = RX_START;
            // Line high again at half-bit: treat as a glitch, no error.
            RX_START: if (w_half_hit) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_hit && r_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_bit_hit) begin
                    w_rx_next    = RX_IDLE;
                    w_byte_valid = r_rx_sync;
                    w_frame_err  = !r_rx_sync;
                end
            end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // Bit-period counter restarts on every state change and at each data bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_rx_state == RX_IDLE || w_rx_next != r_rx_state ||
                (r_rx_state == RX_DATA && w_bit_hit))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_rx_state == RX_START)
                r_bit <= '0;
            else if (r_rx_state == RX_DATA && w_bit_hit) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        P_SYNC, P_TGT, P_ADL, P_ADH, P_CNL, P_CNH, P_DATA, P_DONE
    } p_state_t;

    p_state_t     r_p_state, w_p_next;
    logic         w_p_err;
    logic         r_tgt;
    logic [13:0]  r_adr;
    logic [15:0]  r_pcnt;
    logic [1:0]   r_idx;
    logic [23:0]  r_word;
    logic         r_wen;
    logic [14:0]  r_adr_o;
    logic [31:0]  r_dat;
    logic         r_err;

    always_ff @(posedge clk) begin
        if (rst) r_p_state <= P_SYNC;
        else     r_p_state <= w_p_next;
    end

    always_comb begin
        w_p_next = r_p_state;
        w_p_err  = 1'b0;
        if (w_byte_valid) begin
            case (r_p_state)
                P_SYNC: begin
                    if (r_shift == 8'h5A) w_p_next = P_TGT;
                    else                  w_p_err  = 1'b1;
                end
                P_TGT: begin
                    if (r_shift == 8'h00 || r_shift == 8'h01) w_p_next = P_ADL;
                    else if (r_shift == 8'hFF)                w_p_next = P_DONE;
                    else begin
                        w_p_err  = 1'b1;
                        w_p_next = P_SYNC;
                    end
                end
                P_ADL: w_p_next = P_ADH;
                P_ADH: w_p_next = P_CNL;
                P_CNL: w_p_next = P_CNH;
                P_CNH: w_p_next = ({r_shift, r_pcnt[7:0]} == 16'd0) ? P_SYNC : P_DATA;
                P_DATA: if (r_idx == 2'd3 && r_pcnt == 16'd1) w_p_next = P_SYNC;
                P_DONE: w_p_next = P_DONE;
                default: w_p_next = P_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt   <= 1'b0;
            r_adr   <= '0;
            r_pcnt  <= '0;
            r_idx   <= '0;
            r_word  <= '0;
            r_wen   <= 1'b0;
            r_adr_o <= '0;
            r_dat   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wen <= 1'b0;
            if (w_p_err || w_frame_err) r_err <= 1'b1;
            if (w_byte_valid) begin
                case (r_p_state)
                    P_TGT: r_tgt <= r_shift[0];
                    P_ADL: r_adr[7:0] <= r_shift;
                    P_ADH: r_adr[13:8] <= r_shift[5:0];
                    P_CNL: r_pcnt[7:0] <= r_shift;
                    P_CNH: begin
                        r_pcnt[15:8] <= r_shift;
                        r_idx        <= '0;
                    end
                    P_DATA: begin
                        r_idx <= r_idx + 1'b1;
                        case (r_idx)
                            2'd0: r_word[7:0]   <= r_shift;
                            2'd1: r_word[15:8]  <= r_shift;
                            2'd2: r_word[23:16] <= r_shift;
                            default: begin
                                r_wen   <= 1'b1;
                                r_dat   <= {r_shift, r_word};
                                r_adr_o <= {r_tgt, r_adr};
                                r_adr   <= r_adr + 14'd1;
                                r_pcnt  <= r_pcnt - 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign upg.upg_wen_o  = r_wen;
    assign upg.upg_adr_o  = r_adr_o;
    assign upg.upg_dat_o  = r_dat;
    assign upg.upg_done_o = (r_p_state == P_DONE);
    assign err_o          = r_err;

endmodule

// File: tb/tb_riscv_uart_prog.sv
// tb_riscv_uart_prog
//   Directed bench for riscv_uart_prog: drives framed UART byte streams and
//   checks the captured write strobes, address/data, done and error flags.
module tb_riscv_uart_prog;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic err_o;

    riscv_uart_prog_if upg();

    riscv_uart_prog #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .upg   (upg.master),
        .err_o (err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] wq_adr[$];
    logic [31:0] wq_dat[$];
    int          wen_runs = 0;
    logic        prev_wen = 1'b0;

    always @(negedge clk) begin
        if (upg.upg_wen_o === 1'b1) begin
            wq_adr.push_back(upg.upg_adr_o);
            wq_dat.push_back(upg.upg_dat_o);
            if (prev_wen) wen_runs++;
        end
        prev_wen = (upg.upg_wen_o === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_q();
        wq_adr.delete();
        wq_dat.delete();
    endtask

    // Start on a negedge; byte_valid lands 2 + HALF + 9*CPB edges after the fall.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit chk_done);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (chk_done && i == HALF + 1) chk("done_before_rise", 64'(upg.upg_done_o), 64'd0);
            if (chk_done && i == HALF + 2) chk("done_rise", 64'(upg.upg_done_o), 64'd1);
            if (!stop_ok && i == HALF + 1) rx = 1'b1;
        end
        rx = 1'b1;
        if (!stop_ok) repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_seq(input bq_t bs);
        foreach (bs[i]) send_byte(bs[i], 1'b1, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_write(input int idx, input logic [14:0] adr, input logic [31:0] dat);
        if (idx < wq_adr.size()) begin
            chk($sformatf("wr%0d_adr", idx), 64'(wq_adr[idx]), 64'(adr));
            chk($sformatf("wr%0d_dat", idx), 64'(wq_dat[idx]), 64'(dat));
        end else begin
            chk($sformatf("wr%0d_missing", idx), 64'(wq_adr.size()), 64'(idx + 1));
        end
    endtask

    bq_t seq;

    initial begin
        do_reset();

        // Idle line: nothing happens
        repeat (1000) @(negedge clk);
        chk("rst_wen",  64'(upg.upg_wen_o),  64'd0);
        chk("rst_adr",  64'(upg.upg_adr_o),  64'd0);
        chk("rst_dat",  64'(upg.upg_dat_o),  64'd0);
        chk("rst_done", 64'(upg.upg_done_o), 64'd0);
        chk("rst_err",  64'(err_o),          64'd0);
        chk("idle_nwr", 64'(wq_adr.size()),  64'd0);

        // Data RAM frame, two words
        clear_q();
        seq = '{8'h5A, 8'h01, 8'h10, 8'h00, 8'h02, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq);
        chk("f1_nwr", 64'(wq_adr.size()), 64'd2);
        check_write(0, 15'h4010, 32'h12345678);
        check_write(1, 15'h4011, 32'hDEADBEEF);
        chk("f1_err", 64'(err_o), 64'd0);

        // Instruction frame at 0x3FFF (ADDR_H[7:6] set, ignored) wrapping to 0
        clear_q();
        seq = '{8'h5A, 8'h00, 8'hFF, 8'hFF, 8'h02, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_seq(seq);
        chk("f2_nwr", 64'(wq_adr.size()), 64'd2);
        check_write(0, 15'h3FFF, 32'h44332211);
        check_write(1, 15'h0000, 32'h88776655);
        chk("f2_adr_hold", 64'(upg.upg_adr_o), 64'h0000);

        // Framing error on a data byte, then resend
        clear_q();
        seq = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00};
        send_seq(seq);
        send_byte(8'hAA, 1'b0, 1'b0);
        chk("fe_err", 64'(err_o), 64'd1);
        chk("fe_nwr_mid", 64'(wq_adr.size()), 64'd0);
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_seq(seq);
        chk("fe_nwr", 64'(wq_adr.size()), 64'd1);
        check_write(0, 15'h4000, 32'hDDCCBBAA);
        chk("fe_err_sticky", 64'(err_o), 64'd1);

        do_reset();
        chk("rst2_err", 64'(err_o), 64'd0);

        // Junk before SYNC, then a bad TGT
        clear_q();
        seq = '{8'h33};
        send_seq(seq);
        chk("junk_err", 64'(err_o), 64'd1);
        seq = '{8'h5A, 8'h07};
        send_seq(seq);
        chk("badtgt_nwr", 64'(wq_adr.size()), 64'd0);
        // Zero-count frame, then a valid frame
        seq = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq(seq);
        chk("cnt0_nwr", 64'(wq_adr.size()), 64'd0);
        seq = '{8'h5A, 8'h01, 8'h05, 8'h00, 8'h01, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04};
        send_seq(seq);
        chk("recov_nwr", 64'(wq_adr.size()), 64'd1);
        check_write(0, 15'h4005, 32'h04030201);

        // End frame
        do_reset();
        clear_q();
        send_byte(8'h5A, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b1);
        seq = '{8'h5A, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(seq);
        chk("done_nwr", 64'(wq_adr.size()), 64'd0);
        chk("done_sticky", 64'(upg.upg_done_o), 64'd1);
        chk("done_err", 64'(err_o), 64'd0);
        do_reset();
        chk("done_clr", 64'(upg.upg_done_o), 64'd0);
        chk("done_clr_adr", 64'(upg.upg_adr_o), 64'd0);

        chk("wen_single", 64'(wen_runs), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
